// File: rtl/objmux_pkg.sv
// +----------------------------------------------------------------------------+
// | objmux_pkg                                                                 |
// | Shared mode encoding and constants for the layer priority multiplexer.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package objmux_pkg;

    typedef enum logic [1:0] {
        INTRO     = 2'd0,
        RUNNING   = 2'd1,
        GAME_OVER = 2'd2
    } mode_t;

    localparam logic [7:0]  c_transparent_default = 8'hFF;
    localparam int unsigned c_flash_half_period   = 16;

endpackage

`default_nettype wire

// File: rtl/layer_priority_pick.sv
// +----------------------------------------------------------------------------+
// | layer_priority_pick                                                        |
// | Picks the lowest-index layer that is requested, enabled and not keyed out. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module layer_priority_pick #(
    parameter int COUNT = 8,
    parameter int WIDTH = 8
) (
    input  logic [COUNT-1:0]       i_req,
    input  logic [COUNT-1:0]       i_en,
    input  logic [COUNT*WIDTH-1:0] i_pixel,
    input  logic [WIDTH-1:0]       i_key,
    output logic                   o_hit,
    output logic [WIDTH-1:0]       o_pixel
);

    logic [COUNT-1:0] w_draw;
    logic             w_hit;
    logic [WIDTH-1:0] w_pixel;

    generate
        for (genvar g = 0; g < COUNT; g++) begin : g_draw
            assign w_draw[g] = i_req[g] & i_en[g] &
                               (i_pixel[g*WIDTH +: WIDTH] != i_key);
        end
    endgenerate

    // Scan from the weakest layer upward so layer 0 has the final word.
    always_comb begin
        w_hit   = 1'b0;
        w_pixel = '0;
        for (int i = COUNT - 1; i >= 0; i--) begin
            if (w_draw[i]) begin
                w_hit   = 1'b1;
                w_pixel = i_pixel[i*WIDTH +: WIDTH];
            end
        end
    end

    assign o_hit   = w_hit;
    assign o_pixel = w_pixel;

endmodule

`default_nettype wire

// File: rtl/layer_priority_mux.sv
// +----------------------------------------------------------------------------+
// | layer_priority_mux                                                         |
// | Mode FSM (INTRO/RUNNING/GAME_OVER) plus registered layer compositor.       |
// | Optional: LAYER_PRIORITY_MUX_FLASH_EN makes the game-over overlay blink.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module layer_priority_mux
    import objmux_pkg::*;
#(
    parameter int                 NUM_LAYERS  = 8,
    parameter int                 PIXEL_W     = 8,
    parameter int                 NUM_INTRO   = 3,
    parameter logic [PIXEL_W-1:0] TRANSPARENT = 8'hFF,
    parameter int                 HOLD_FRAMES = 60
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          startOfFrame,
    input  logic [NUM_LAYERS-1:0]         layerDrawingRequest,
    input  logic [NUM_LAYERS*PIXEL_W-1:0] layerRGB,
    input  logic [NUM_LAYERS-1:0]         layerEnable,
    input  logic [PIXEL_W-1:0]            background_RGB,
    input  logic [NUM_INTRO-1:0]          introDrawingRequest,
    input  logic [NUM_INTRO*PIXEL_W-1:0]  introRGB,
    input  logic                          gameOverDrawingRequest,
    input  logic [PIXEL_W-1:0]            gameOverRGB,
    input  logic                          enterKey,
    input  logic                          gameOverEvent,
    output logic [PIXEL_W-1:0]            RGBOut,
    output logic                          game_running,
    output logic [1:0]                    mode
);

    localparam int                c_CNT_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [c_CNT_W-1:0] c_hold = c_CNT_W'(HOLD_FRAMES);

    mode_t               r_state;
    mode_t               r_pend_target;
    logic                r_pend_valid;
    logic                r_enter_prev;
    logic                r_game_running;
    logic [c_CNT_W-1:0]  r_frame_cnt;
    logic [PIXEL_W-1:0]  r_rgb;

    logic                w_enter_edge;
    logic                w_req;
    mode_t               w_req_target;
    logic                w_apply_go;
    logic                w_game_hit;
    logic [PIXEL_W-1:0]  w_game_pick;
    logic                w_intro_hit;
    logic [PIXEL_W-1:0]  w_intro_pick;
    logic                w_over_draw;
    logic                w_overlay_shown;
    logic [PIXEL_W-1:0]  w_game_pixel;
    logic [PIXEL_W-1:0]  w_next_rgb;

    layer_priority_pick #(
        .COUNT (NUM_LAYERS),
        .WIDTH (PIXEL_W)
    ) u_game_pick (
        .i_req   (layerDrawingRequest),
        .i_en    (layerEnable),
        .i_pixel (layerRGB),
        .i_key   (TRANSPARENT),
        .o_hit   (w_game_hit),
        .o_pixel (w_game_pick)
    );

    layer_priority_pick #(
        .COUNT (NUM_INTRO),
        .WIDTH (PIXEL_W)
    ) u_intro_pick (
        .i_req   (introDrawingRequest),
        .i_en    ({NUM_INTRO{1'b1}}),
        .i_pixel (introRGB),
        .i_key   (TRANSPARENT),
        .o_hit   (w_intro_hit),
        .o_pixel (w_intro_pick)
    );

    assign w_enter_edge = enterKey & ~r_enter_prev;
    assign w_apply_go   = startOfFrame & r_pend_valid & (r_pend_target == GAME_OVER);
    assign w_over_draw  = gameOverDrawingRequest & (gameOverRGB != TRANSPARENT);

    // gameOverEvent is tested first so it wins over a coincident enter edge.
    always_comb begin
        w_req        = 1'b0;
        w_req_target = r_state;
        if (r_state == RUNNING && gameOverEvent) begin
            w_req        = 1'b1;
            w_req_target = GAME_OVER;
        end else if (r_state == INTRO && w_enter_edge) begin
            w_req        = 1'b1;
            w_req_target = RUNNING;
        end else if (r_state == GAME_OVER && w_enter_edge && r_frame_cnt >= c_hold) begin
            w_req        = 1'b1;
            w_req_target = INTRO;
        end
    end

`ifdef LAYER_PRIORITY_MUX_FLASH_EN
    localparam int c_PHASE_W = $clog2(2 * c_flash_half_period);

    logic [c_PHASE_W-1:0] r_phase;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_phase <= '0;
        end else if (w_apply_go) begin
            r_phase <= '0;
        end else if (startOfFrame && r_state == GAME_OVER) begin
            r_phase <= r_phase + 1'b1;
        end
    end

    assign w_overlay_shown = (r_phase < c_PHASE_W'(c_flash_half_period));
`else
    assign w_overlay_shown = 1'b1;
`endif

    always_comb begin
        w_game_pixel = w_game_hit ? w_game_pick : background_RGB;
        case (r_state)
            INTRO:     w_next_rgb = w_intro_hit ? w_intro_pick : '0;
            RUNNING:   w_next_rgb = w_game_pixel;
            GAME_OVER: w_next_rgb = (w_over_draw && w_overlay_shown) ? gameOverRGB : w_game_pixel;
            default:   w_next_rgb = '0;
        endcase
    end

    // Mode changes are deferred to startOfFrame so a frame never mixes modes.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state        <= INTRO;
            r_pend_target  <= INTRO;
            r_pend_valid   <= 1'b0;
            r_enter_prev   <= 1'b0;
            r_game_running <= 1'b0;
            r_frame_cnt    <= '0;
            r_rgb          <= '0;
        end else begin
            r_enter_prev <= enterKey;
            r_rgb        <= w_next_rgb;

            if (startOfFrame && r_pend_valid) begin
                r_state        <= r_pend_target;
                r_game_running <= (r_pend_target == RUNNING);
            end

            if (w_req) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= w_req_target;
            end else if (startOfFrame) begin
                r_pend_valid  <= 1'b0;
            end

            if (w_apply_go) begin
                r_frame_cnt <= '0;
            end else if (startOfFrame && r_state == GAME_OVER && r_frame_cnt != c_hold) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign RGBOut       = r_rgb;
    assign game_running = r_game_running;
    assign mode         = r_state;

endmodule

`default_nettype wire
